cvfpu_arbiter: RTL

Round-robin scheduler that shares one vector FPU instance (the fpnew-based CVFPU wrapper) among NUM_REQ requesters, such as warp issue slots. It registers one winning request per cycle toward the FPU. It prepends the requester ID to the FPU tag and steers each FPU response back to its owner by that ID. Per-requester in-flight credits keep one requester from filling the FPU pipeline.

---
 rtl/cvfpu_arb_pkg.sv | 34 +++
 rtl/cvfpu_arbiter_rr.sv | 55 +++++
 rtl/cvfpu_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cvfpu_arb_pkg.sv
// -----------------------------------------------------------------------------
// cvfpu_arb_pkg
// Shared types and helpers for the CVFPU request arbiter.
//   CTRL_W     : width of the packed FPU control word
//   STATUS_W   : width of the FPU exception-status flags
//   fpu_ctrl_t : FPU control word, field order matches the in_ctrl slices
//   tagId()    : pulls the requester ID out of an FPU-side tag
// -----------------------------------------------------------------------------
package cvfpu_arb_pkg;

   localparam int CTRL_W   = 32;
   localparam int STATUS_W = 5;

   typedef struct packed {
      logic [15:0] simdMask;
      logic [2:0]  roundingMode;
      logic [4:0]  op;
      logic [2:0]  srcFormat;
      logic [2:0]  dstFormat;
      logic [1:0]  intFormat;
   } fpu_ctrl_t;

   // The requester ID sits directly above the requester's own tag bits.
   function automatic int unsigned tagId(input logic [31:0] tag,
                                         input int unsigned tagW,
                                         input int unsigned idW);
      logic [31:0] shifted;
      logic [31:0] mask;
      shifted = tag >> tagW;
      mask    = (32'd1 << idW) - 32'd1;
      return shifted & mask;
   endfunction

endpackage

// File: rtl/cvfpu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Pointer-based round-robin selector. The first requesting line at or after
// the priority pointer (wrapping) wins. The pointer moves to winner+1 only
// when the caller reports that the grant was actually taken.
// Ports:
//   clock, reset : clock, synchronous active-high reset
//   i_req        : request vector (already filtered for eligibility)
//   i_advance    : grant consumed this cycle, move the pointer
//   o_grant      : one-hot grant (all zero when nothing requests)
//   o_grantIdx   : binary index of the granted line
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_grantIdx
);

   logic [IDX_W-1:0] r_ptr;

   // Walk the requesters starting from the pointer and stop at the first hit.
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      o_grant    = '0;
      o_grantIdx = '0;
      found      = 1'b0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!found && i_req[cand]) begin
            found         = 1'b1;
            o_grant[cand] = 1'b1;
            o_grantIdx    = cand;
         end
      end
   end

   // The pointer only moves on a consumed grant, so a blocked winner keeps
   // its priority until it gets through.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_advance) begin
         r_ptr <= (o_grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grantIdx + 1'b1;
      end
   end

endmodule

// File: rtl/cvfpu_arbiter.sv
// -----------------------------------------------------------------------------
// cvfpu_arbiter
// Shares one CVFPU instance among NUM_REQ requesters. One round-robin winner
// per cycle is captured into a single request register toward the FPU; the
// winner's ID is prepended to its tag so the response can be steered back.
// Per-requester credit counters bound the number of ops each requester can
// have in flight.
// Optional feature macro: CVFPU_ARB_PERF_EN enables the performance counters;
// without it the perf ports are tied to zero.
// Ports:
//   clock, reset                    : clock, synchronous active-high reset
//   in_valid/in_ready               : per-requester request handshake
//   in_operands_0/1/2, in_ctrl,
//   in_tag                          : per-requester request payload slices
//   out_valid/out_ready             : per-requester response handshake
//   out_result/out_status/out_tag   : shared response bus
//   fpu_req_*                       : registered request toward the FPU
//   fpu_resp_*                      : response from the FPU
//   flush/fpu_flush                 : pipeline flush in, forwarded to the FPU
//   busy                            : request pending or any op in flight
//   perf_issued/perf_stalled        : 32-bit counters per requester
// -----------------------------------------------------------------------------
module cvfpu_arbiter
   import cvfpu_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int WIDTH        = 512,
   parameter int TAG_WIDTH    = 4,
   parameter int MAX_INFLIGHT = 8,
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          in_valid,
   output logic [NUM_REQ-1:0]          in_ready,
   input  logic [NUM_REQ*WIDTH-1:0]    in_operands_0,
   input  logic [NUM_REQ*WIDTH-1:0]    in_operands_1,
   input  logic [NUM_REQ*WIDTH-1:0]    in_operands_2,
   input  logic [NUM_REQ*CTRL_W-1:0]   in_ctrl,
   input  logic [NUM_REQ*TAG_WIDTH-1:0] in_tag,
   output logic [NUM_REQ-1:0]          out_valid,
   input  logic [NUM_REQ-1:0]          out_ready,
   output logic [WIDTH-1:0]            out_result,
   output logic [STATUS_W-1:0]         out_status,
   output logic [TAG_WIDTH-1:0]        out_tag,
   output logic                        fpu_req_valid,
   input  logic                        fpu_req_ready,
   output logic [WIDTH-1:0]            fpu_req_operands_0,
   output logic [WIDTH-1:0]            fpu_req_operands_1,
   output logic [WIDTH-1:0]            fpu_req_operands_2,
   output logic [CTRL_W-1:0]           fpu_req_ctrl,
   output logic [ID_W+TAG_WIDTH-1:0]   fpu_req_tag,
   input  logic                        fpu_resp_valid,
   output logic                        fpu_resp_ready,
   input  logic [WIDTH-1:0]            fpu_resp_result,
   input  logic [STATUS_W-1:0]         fpu_resp_status,
   input  logic [ID_W+TAG_WIDTH-1:0]   fpu_resp_tag,
   input  logic                        flush,
   output logic                        fpu_flush,
   output logic                        busy,
   output logic [NUM_REQ*32-1:0]       perf_issued,
   output logic [NUM_REQ*32-1:0]       perf_stalled
);

   localparam int FTAG_W = ID_W + TAG_WIDTH;
   localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

   logic              r_reqValid;
   logic [WIDTH-1:0]  r_op0;
   logic [WIDTH-1:0]  r_op1;
   logic [WIDTH-1:0]  r_op2;
   fpu_ctrl_t         r_ctrl;
   logic [FTAG_W-1:0] r_tag;
   logic [CNT_W-1:0]  r_cnt [NUM_REQ];

   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_accept;
   logic [NUM_REQ-1:0] w_idSel;
   logic [NUM_REQ-1:0] w_respFire;
   logic [ID_W-1:0]    w_grantIdx;
   logic [ID_W-1:0]    w_respId;
   logic               w_canLoad;
   logic               w_anyAccept;
   logic               w_anyCnt;

   // A requester competes only while it still has a free credit.
   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_eligible[i] = in_valid[i] && (r_cnt[i] < CNT_MAX);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (ID_W)
   ) u_rr (
      .clock      (clock),
      .reset      (reset),
      .i_req      (w_eligible),
      .i_advance  (w_anyAccept),
      .o_grant    (w_grant),
      .o_grantIdx (w_grantIdx)
   );

   // The register can take a new op when empty or when its current op is
   // leaving this very cycle. Flush blocks all new accepts.
   assign w_canLoad   = !r_reqValid || fpu_req_ready;
   assign w_accept    = w_grant & {NUM_REQ{w_canLoad && !flush}};
   assign w_anyAccept = |w_accept;
   assign in_ready    = w_accept;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_reqValid <= 1'b0;
         r_op0      <= '0;
         r_op1      <= '0;
         r_op2      <= '0;
         r_ctrl     <= '0;
         r_tag      <= '0;
      end else if (flush) begin
         r_reqValid <= 1'b0;
      end else if (w_canLoad) begin
         r_reqValid <= w_anyAccept;
         if (w_anyAccept) begin
            r_op0  <= in_operands_0[int'(w_grantIdx)*WIDTH +: WIDTH];
            r_op1  <= in_operands_1[int'(w_grantIdx)*WIDTH +: WIDTH];
            r_op2  <= in_operands_2[int'(w_grantIdx)*WIDTH +: WIDTH];
            r_ctrl <= fpu_ctrl_t'(in_ctrl[int'(w_grantIdx)*CTRL_W +: CTRL_W]);
            r_tag  <= {w_grantIdx, in_tag[int'(w_grantIdx)*TAG_WIDTH +: TAG_WIDTH]};
         end
      end
   end

   assign fpu_req_valid      = r_reqValid;
   assign fpu_req_operands_0 = r_op0;
   assign fpu_req_operands_1 = r_op1;
   assign fpu_req_operands_2 = r_op2;
   assign fpu_req_ctrl       = r_ctrl;
   assign fpu_req_tag        = r_tag;

   // Response steering is purely combinational; the ID in the upper tag bits
   // selects the owner. During flush the response is neither delivered nor
   // acknowledged.
   assign w_respId = ID_W'(tagId(32'(fpu_resp_tag), TAG_WIDTH, ID_W));

   always_comb begin
      w_idSel   = '0;
      out_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idSel[i]   = (w_respId == ID_W'(i));
         out_valid[i] = fpu_resp_valid && !flush && w_idSel[i];
      end
   end

   assign fpu_resp_ready = !flush && (|(out_ready & w_idSel));
   assign out_result     = fpu_resp_result;
   assign out_status     = fpu_resp_status;
   assign out_tag        = fpu_resp_tag[TAG_WIDTH-1:0];
   assign w_respFire     = out_valid & out_ready;
   assign fpu_flush      = flush;

   // Credits: +1 on accept, -1 on delivered response, unchanged if both.
   // Flush wipes them since everything in flight is being discarded.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset || flush) begin
            r_cnt[i] <= '0;
         end else if (w_accept[i] && !w_respFire[i]) begin
            if (r_cnt[i] != CNT_MAX) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end else if (!w_accept[i] && w_respFire[i]) begin
            if (r_cnt[i] != '0) begin
               r_cnt[i] <= r_cnt[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_anyCnt = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_anyCnt = w_anyCnt || (r_cnt[i] != '0);
      end
   end

   assign busy = r_reqValid || w_anyCnt;

`ifdef CVFPU_ARB_PERF_EN
   logic [31:0] r_perfIssued  [NUM_REQ];
   logic [31:0] r_perfStalled [NUM_REQ];

   // Counters survive flush so long-running statistics are not lost.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset) begin
            r_perfIssued[i]  <= '0;
            r_perfStalled[i] <= '0;
         end else begin
            if (w_accept[i]) begin
               r_perfIssued[i] <= r_perfIssued[i] + 32'd1;
            end
            if (in_valid[i] && !in_ready[i]) begin
               r_perfStalled[i] <= r_perfStalled[i] + 32'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
      assign perf_issued[g*32 +: 32]  = r_perfIssued[g];
      assign perf_stalled[g*32 +: 32] = r_perfStalled[g];
   end
`else
   assign perf_issued  = '0;
   assign perf_stalled = '0;
`endif

endmodule
